// File: rtl/mem_ctrl_param_if.sv
// Request/response channel between the bus agent (master) and mem_ctrl_param (slave).
// Signal suffixes are from the memory controller's point of view.
interface mem_ctrl_param_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
);
    logic                      valid_i;
    logic                      ready_o;
    logic                      wr_rd_i;
    logic [ADDR_WIDTH-1:0]     addr_i;
    logic [DATA_WIDTH-1:0]     wdata_i;
    logic [DATA_WIDTH/8-1:0]   wstrb_i;
    logic                      resp_valid_o;
    logic                      resp_ready_i;
    logic [DATA_WIDTH-1:0]     rdata_o;
    logic                      err_o;

    modport master (
        output valid_i, wr_rd_i, addr_i, wdata_i, wstrb_i, resp_ready_i,
        input  ready_o, resp_valid_o, rdata_o, err_o
    );

    modport slave (
        input  valid_i, wr_rd_i, addr_i, wdata_i, wstrb_i, resp_ready_i,
        output ready_o, resp_valid_o, rdata_o, err_o
    );
endinterface

// File: rtl/mem_ctrl_param.sv
// Word memory with byte strobes, a four-register CSR window at the top of the
// address space, registered responses and a one-word-per-cycle clear engine.
//   state   | meaning
//   S_IDLE  | requests served; waits for CTRL.clr write or post-reset init
//   S_CLEAR | writes 0 to word idx_q each cycle, requests blocked
module mem_ctrl_param #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = 8,
    parameter bit INIT_CLEAR = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    mem_ctrl_param_if.slave    bus,
    output logic               clear_busy_o
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] A_DEPTH    = ADDR_WIDTH'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] A_SCRATCH  = ADDR_WIDTH'((1 << ADDR_WIDTH) - 4);
    localparam logic [ADDR_WIDTH-1:0] A_CTRL     = ADDR_WIDTH'((1 << ADDR_WIDTH) - 3);
    localparam logic [ADDR_WIDTH-1:0] A_STATUS   = ADDR_WIDTH'((1 << ADDR_WIDTH) - 2);
    localparam logic [ADDR_WIDTH-1:0] A_WR_COUNT = ADDR_WIDTH'((1 << ADDR_WIDTH) - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(DEPTH - 1);

    typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  alive_q;
    logic                  wp_q, wp_d;
    logic                  sticky_q, sticky_d;
    logic [DATA_WIDTH-1:0] scratch_q, scratch_d;
    logic [DATA_WIDTH-1:0] wr_count_q, wr_count_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  accept, is_mem, is_scratch, is_ctrl, is_status, is_count;
    logic                  req_err, mem_we, clr_start;
    logic [IDX_W-1:0]      req_idx;

    assign clear_busy_o     = (state_q == S_CLEAR);
    // alive_q holds ready low during reset and for the first cycle after release
    assign bus.ready_o      = alive_q && !clear_busy_o && (!resp_valid_q || bus.resp_ready_i);
    assign bus.resp_valid_o = resp_valid_q;
    assign bus.rdata_o      = rdata_q;
    assign bus.err_o        = err_q;

    assign accept     = bus.valid_i && bus.ready_o;
    assign is_mem     = (bus.addr_i < A_DEPTH);
    assign is_scratch = (bus.addr_i == A_SCRATCH);
    assign is_ctrl    = (bus.addr_i == A_CTRL);
    assign is_status  = (bus.addr_i == A_STATUS);
    assign is_count   = (bus.addr_i == A_WR_COUNT);
    assign req_idx    = bus.addr_i[IDX_W-1:0];
    assign req_err    = !(is_mem || is_scratch || is_ctrl || is_status || is_count)
                        || (is_mem && bus.wr_rd_i && wp_q);
    assign mem_we     = accept && bus.wr_rd_i && is_mem && !req_err;
    assign clr_start  = (accept && bus.wr_rd_i && is_ctrl && bus.wdata_i[1])
                        || (!alive_q && INIT_CLEAR);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (clr_start) begin
                    state_d = S_CLEAR;
                    idx_d   = '0;
                end
            end
            S_CLEAR: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == IDX_LAST) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wp_d         = wp_q;
        sticky_d     = sticky_q;
        scratch_d    = scratch_q;
        wr_count_d   = wr_count_q;
        resp_valid_d = resp_valid_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        if (accept) begin
            resp_valid_d = 1'b1;
            err_d        = req_err;
            rdata_d      = '0;
            if (!req_err) begin
                if (bus.wr_rd_i) begin
                    if (is_mem)     wr_count_d = wr_count_q + 1'b1;
                    if (is_scratch) scratch_d  = bus.wdata_i;
                    if (is_ctrl)    wp_d       = bus.wdata_i[0];
                    if (is_status && bus.wdata_i[1]) sticky_d = 1'b0;
                    if (is_count)   wr_count_d = '0;
                end else begin
                    if (is_mem)     rdata_d = mem_q[req_idx];
                    if (is_scratch) rdata_d = scratch_q;
                    if (is_ctrl)    rdata_d = DATA_WIDTH'(wp_q);
                    if (is_status)  rdata_d = DATA_WIDTH'({sticky_q, clear_busy_o});
                    if (is_count)   rdata_d = wr_count_q;
                end
            end
        end else if (bus.resp_ready_i) begin
            resp_valid_d = 1'b0;
            rdata_d      = '0;
            err_d        = 1'b0;
        end
        // a new error outranks a same-cycle W1C
        if (accept && req_err) sticky_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            alive_q      <= 1'b0;
            wp_q         <= 1'b0;
            sticky_q     <= 1'b0;
            scratch_q    <= '0;
            wr_count_q   <= '0;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            alive_q      <= 1'b1;
            wp_q         <= wp_d;
            sticky_q     <= sticky_d;
            scratch_q    <= scratch_d;
            wr_count_q   <= wr_count_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

    // Storage is deliberately not reset; the clear engine initialises it.
    always_ff @(posedge clk_i) begin
        if (clear_busy_o) begin
            mem_q[idx_q] <= '0;
        end else if (mem_we) begin
            for (int k = 0; k < STRB_W; k++) begin
                if (bus.wstrb_i[k]) mem_q[req_idx][8*k +: 8] <= bus.wdata_i[8*k +: 8];
            end
        end
    end
endmodule
